ssd_scan_driver: RTL and testbench

//  Time-multiplexed scan driver for a 4-digit common-anode seven-segment display.

---
 rtl/ssd_scan_driver.sv | 123 ++++++++++++
 tb/tb_ssd_scan_driver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - 4-digit seven-segment scan driver with double-buffered value and anti-ghost guard
module ssd_scan_driver #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic        value_load,
  output logic [3:0]  input_bits,
  output logic [3:0]  dig_sel,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   display_q, display_d;
  logic [15:0]   pending_q, pending_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    input_bits_q, input_bits_d;
  logic [3:0]    dig_sel_q, dig_sel_d;
  logic          wrap;

  function automatic logic [3:0] nib(input logic [15:0] d, input logic [1:0] i);
    case (i)
      2'd0:    return d[3:0];
      2'd1:    return d[7:4];
      2'd2:    return d[11:8];
      default: return d[15:12];
    endcase
  endfunction

  // Digit k>0 is a leading zero when it and every higher nibble are zero.
  function automatic logic lz(input logic [15:0] d, input logic [1:0] i);
    case (i)
      2'd0:    return 1'b0;
      2'd1:    return d[15:4] == 12'h000;
      2'd2:    return d[15:8] == 8'h00;
      default: return d[15:12] == 4'h0;
    endcase
  endfunction

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    display_d    = display_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    wrap         = 1'b0;
    if (!enable) begin
      cnt_d = '0;
      idx_d = 2'd0;
      if (busy_q) display_d = pending_q;
      busy_d = value_load;
      if (value_load) pending_d = value;
    end else begin
      wrap = (cnt_q == CNT_MAX) && (idx_q == 2'd3);
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (value_load) begin
        pending_d = value;
        busy_d    = 1'b1;
      end
      // A load landing on the wrap edge bypasses the buffer so the newer value wins.
      if (wrap) begin
        frame_done_d = 1'b1;
        if (value_load) begin
          display_d = value;
          busy_d    = 1'b0;
        end else if (busy_q) begin
          display_d = pending_q;
          busy_d    = 1'b0;
        end
      end
    end
    input_bits_d = nib(display_d, idx_d);
    if (!enable || (cnt_d < BLANK_C) || ((LZ_BLANK != 0) && lz(display_d, idx_d)))
      dig_sel_d = 4'b1111;
    else
      dig_sel_d = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      display_q    <= 16'h0000;
      pending_q    <= 16'h0000;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      input_bits_q <= 4'h0;
      dig_sel_q    <= 4'b1111;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      input_bits_q <= input_bits_d;
      dig_sel_q    <= dig_sel_d;
    end
  end

  assign input_bits = input_bits_q;
  assign dig_sel    = dig_sel_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - directed self-checking bench for ssd_scan_driver
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] value;
  logic        value_load;
  logic [3:0]  input_bits, dig_sel, lz_input_bits, lz_dig_sel;
  logic        busy, frame_done, lz_busy, lz_frame_done;

  int errors = 0;
  int checks = 0;
  int pos = 0;

  always #5 clk = ~clk;

  ssd_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .value_load(value_load),
    .input_bits(input_bits), .dig_sel(dig_sel), .busy(busy), .frame_done(frame_done)
  );

  ssd_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .value_load(value_load),
    .input_bits(lz_input_bits), .dig_sel(lz_dig_sel), .busy(lz_busy), .frame_done(lz_frame_done)
  );

  // pos = idx*8 + cnt as expected after the most recent edge
  task automatic tick();
    @(posedge clk);
    if (!rst_n || !enable) pos = 0;
    else pos = (pos + 1) % 32;
    #1;
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (pos != target && n < 80) begin
      tick();
      n++;
    end
    if (pos != target) begin
      errors++;
      $display("FAIL run_to: pos=%0d required=%0d", pos, target);
    end
  endtask

  task automatic load(input logic [15:0] v);
    value = v;
    value_load = 1'b1;
    tick();
    value_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b1; value = 16'h0000; value_load = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dig_sel !== 4'b1111 || input_bits !== 4'h0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dig_sel=%b ib=%h busy=%b fd=%b required 1111/0/0/0", dig_sel, input_bits, busy, frame_done);
    end
    tick(); tick();
    rst_n = 1'b1;
    pos = 0;
    tick();
    checks++;
    if (dig_sel !== 4'b1111 || input_bits !== 4'h0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: dig_sel=%b ib=%h busy=%b fd=%b required 1111/0/0/0", dig_sel, input_bits, busy, frame_done);
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0] ib_tab [4];
    logic [3:0] exp_sel;
    ib_tab = '{4'h4, 4'h3, 4'h2, 4'h1};
    load(16'h1234);
    checks++;
    if (busy !== 1'b1 || input_bits !== 4'h0) begin
      errors++;
      $display("FAIL t1_pending: busy=%b ib=%h required 1/0", busy, input_bits);
    end
    run_to(31);
    tick();
    for (int k = 0; k < 32; k++) begin
      exp_sel = ((k % 8) < 2) ? 4'b1111 : ~(4'b0001 << (k / 8));
      checks++;
      if (input_bits !== ib_tab[k / 8] || dig_sel !== exp_sel || frame_done !== (k == 0) || busy !== 1'b0) begin
        errors++;
        $display("FAIL t1_scan k=%0d: ib=%h sel=%b fd=%b busy=%b required %h/%b/%b/0",
                 k, input_bits, dig_sel, frame_done, busy, ib_tab[k / 8], exp_sel, (k == 0));
      end
      tick();
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL t1_period: fd=%b required 1", frame_done);
    end
  endtask

  task automatic test_mid_frame_load();
    run_to(11);
    load(16'hABCD);
    checks++;
    if (busy !== 1'b1 || input_bits !== 4'h3 || dig_sel !== 4'b1101) begin
      errors++;
      $display("FAIL t2_after_load: busy=%b ib=%h sel=%b required 1/3/1101", busy, input_bits, dig_sel);
    end
    run_to(20);
    checks++;
    if (busy !== 1'b1 || input_bits !== 4'h2) begin
      errors++;
      $display("FAIL t2_digit2: busy=%b ib=%h required 1/2", busy, input_bits);
    end
    run_to(31);
    checks++;
    if (busy !== 1'b1 || input_bits !== 4'h1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL t2_digit3: busy=%b ib=%h fd=%b required 1/1/0", busy, input_bits, frame_done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || input_bits !== 4'hD || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL t2_wrap: busy=%b ib=%h fd=%b required 0/D/1", busy, input_bits, frame_done);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL t2_fd_width: fd=%b required 0", frame_done);
    end
  endtask

  task automatic test_lz_blank();
    logic [3:0] sel_tab [4];
    logic [3:0] ib_tab [4];
    logic [3:0] exp_sel;
    sel_tab = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    ib_tab  = '{4'h0, 4'h5, 4'h0, 4'h0};
    load(16'h0050);
    run_to(31);
    tick();
    for (int k = 0; k < 32; k++) begin
      exp_sel = ((k % 8) < 2) ? 4'b1111 : sel_tab[k / 8];
      checks++;
      if (lz_input_bits !== ib_tab[k / 8] || lz_dig_sel !== exp_sel) begin
        errors++;
        $display("FAIL t3_lz_0050 k=%0d: ib=%h sel=%b required %h/%b", k, lz_input_bits, lz_dig_sel, ib_tab[k / 8], exp_sel);
      end
      tick();
    end
    load(16'h0000);
    run_to(31);
    tick();
    for (int k = 0; k < 32; k++) begin
      exp_sel = ((k / 8) == 0 && (k % 8) >= 2) ? 4'b1110 : 4'b1111;
      checks++;
      if (lz_input_bits !== 4'h0 || lz_dig_sel !== exp_sel) begin
        errors++;
        $display("FAIL t3_lz_0000 k=%0d: ib=%h sel=%b required 0/%b", k, lz_input_bits, lz_dig_sel, exp_sel);
      end
      tick();
    end
  endtask

  task automatic test_wrap_load();
    run_to(10);
    load(16'h1111);
    run_to(31);
    checks++;
    if (busy !== 1'b1 || input_bits !== 4'h0) begin
      errors++;
      $display("FAIL t4_before: busy=%b ib=%h required 1/0", busy, input_bits);
    end
    load(16'h2222);
    checks++;
    if (busy !== 1'b0 || input_bits !== 4'h2 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL t4_wrap: busy=%b ib=%h fd=%b required 0/2/1", busy, input_bits, frame_done);
    end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (input_bits !== 4'h2 || busy !== 1'b0) begin
        errors++;
        $display("FAIL t4_frame k=%0d: ib=%h busy=%b required 2/0", k, input_bits, busy);
      end
      tick();
    end
  endtask

  task automatic test_enable();
    run_to(16);
    enable = 1'b0;
    tick();
    checks++;
    if (dig_sel !== 4'b1111 || input_bits !== 4'h2 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL t5_disable: sel=%b ib=%h fd=%b required 1111/2/0", dig_sel, input_bits, frame_done);
    end
    load(16'h00F0);
    checks++;
    if (busy !== 1'b1 || input_bits !== 4'h2 || dig_sel !== 4'b1111) begin
      errors++;
      $display("FAIL t5_load_off: busy=%b ib=%h sel=%b required 1/2/1111", busy, input_bits, dig_sel);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || input_bits !== 4'h0 || frame_done !== 1'b0 || dig_sel !== 4'b1111) begin
      errors++;
      $display("FAIL t5_xfer_off: busy=%b ib=%h fd=%b sel=%b required 0/0/0/1111", busy, input_bits, frame_done, dig_sel);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (dig_sel !== 4'b1111 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL t5_guard: sel=%b fd=%b required 1111/0", dig_sel, frame_done);
    end
    tick();
    checks++;
    if (dig_sel !== 4'b1110 || input_bits !== 4'h0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL t5_resume: sel=%b ib=%h fd=%b required 1110/0/0", dig_sel, input_bits, frame_done);
    end
  endtask

  task automatic test_async_reset();
    load(16'h3456);
    run_to(29);
    checks++;
    if (busy !== 1'b1 || dig_sel !== 4'b0111 || input_bits !== 4'h0) begin
      errors++;
      $display("FAIL t6_before: busy=%b sel=%b ib=%h required 1/0111/0", busy, dig_sel, input_bits);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dig_sel !== 4'b1111 || busy !== 1'b0 || input_bits !== 4'h0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL t6_async: sel=%b busy=%b ib=%h fd=%b required 1111/0/0/0", dig_sel, busy, input_bits, frame_done);
    end
    tick();
    rst_n = 1'b1;
    pos = 0;
    tick();
    checks++;
    if (dig_sel !== 4'b1111 || busy !== 1'b0 || input_bits !== 4'h0) begin
      errors++;
      $display("FAIL t6_restart: sel=%b busy=%b ib=%h required 1111/0/0", dig_sel, busy, input_bits);
    end
    run_to(2);
    checks++;
    if (dig_sel !== 4'b1110 || input_bits !== 4'h0) begin
      errors++;
      $display("FAIL t6_digit0: sel=%b ib=%h required 1110/0", dig_sel, input_bits);
    end
    run_to(10);
    checks++;
    if (dig_sel !== 4'b1101 || input_bits !== 4'h0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL t6_cleared: sel=%b ib=%h fd=%b required 1101/0/0", dig_sel, input_bits, frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_mid_frame_load();
    test_lz_blank();
    test_wrap_load();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
